// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES request scheduler.
// Data/key widths, op encodings and the scheduler state enum.
package aes_ctrl_pkg;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 64;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/aes_rr_picker.sv
// Combinational round-robin picker.
// Grants the first eligible requester found at ptr, ptr+1, ... mod N.
module aes_rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk from the farthest offset back to ptr so the nearest one wins
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (elig[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one AES core between NREQ requesters.
// Round-robin accept, we/re strobe, fixed-latency wait, tagged result.
module aes_req_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int CORE_LAT   = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int IW         = $clog2(NREQ),
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_W-1:0]       key,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_op,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IW-1:0]          rsp_id,
    output logic                   rsp_op,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   aes_we,
    output logic                   aes_re,
    output logic [DATA_W-1:0]      aes_data,
    output logic [KEY_W-1:0]       aes_key,
    input  logic [DATA_W-1:0]      aes_encrypt_data,
    input  logic [DATA_W-1:0]      aes_decrypt_data,
    output logic [CW-1:0]          fifo_count,
    output logic                   busy
);

    localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       rr_nxt;
    logic [IW-1:0]       cur_id;
    logic                cur_op;
    logic [LW-1:0]       lat_cnt;
    logic [NREQ-1:0]     elig;
    logic [NREQ-1:0]     grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                accept;
    logic [DATA_W-1:0]   core_out;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [IW-1:0]       rsp_id_q;
    logic                rsp_op_q;

    // Encrypt needs room in the core FIFO, decrypt needs an entry
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_op[i] == OP_ENC)
                elig[i] = req_valid[i] && (fifo_count < CW'(FIFO_DEPTH));
            else
                elig[i] = req_valid[i] && (fifo_count != '0);
        end
    end

    aes_rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_picker (
        .elig  (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign accept    = (state == IDLE) && pick_any;
    assign req_ready = (state == IDLE) ? grant : '0;
    assign rr_nxt    = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);

    assign aes_we    = (state == ISSUE) && (cur_op == OP_ENC);
    assign aes_re    = (state == ISSUE) && (cur_op == OP_DEC);
    assign busy      = (state != IDLE);

    assign core_out  = (cur_op == OP_DEC) ? aes_decrypt_data : aes_encrypt_data;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_valid ? core_out : rsp_data_q;
    assign rsp_id    = rsp_valid ? cur_id : rsp_id_q;
    assign rsp_op    = rsp_valid ? cur_op : rsp_op_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: one op in flight, IDLE->ISSUE->WAIT->RESP
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, FIFO occupancy, latency counter, held response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            cur_op     <= OP_ENC;
            aes_data   <= '0;
            aes_key    <= '0;
            fifo_count <= '0;
            lat_cnt    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_op_q   <= 1'b0;
        end else begin
            if (accept) begin
                cur_id   <= pick_idx;
                cur_op   <= req_op[pick_idx];
                aes_data <= req_data[DATA_W*pick_idx +: DATA_W];
                aes_key  <= key;
                rr_ptr   <= rr_nxt;
            end
            if (state == ISSUE) begin
                if (cur_op == OP_ENC) fifo_count <= fifo_count + CW'(1);
                else                  fifo_count <= fifo_count - CW'(1);
                lat_cnt <= LW'(CORE_LAT - 1);
            end
            if (state == WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - LW'(1);
            if (state == RESP) begin
                rsp_data_q <= core_out;
                rsp_id_q   <= cur_id;
                rsp_op_q   <= cur_op;
            end
        end
    end

endmodule
